// File: rtl/pio_tctrl.sv
// -----------------------------------------------------------------------------
// pio_tctrl
// ATA PIO-mode transfer sequencer (OCIDEC-1 host). A single-cycle go request
// runs one complete PIO cycle: address setup (t1), strobe active (t2, optionally
// stretched by IORDY) and end-of-cycle recovery (teoc). One run-once phase
// counter is reloaded at each phase boundary.
//
// Ports
//   i_clk      master clock
//   i_nReset   synchronous active-low reset
//   i_go       start request, accepted only in IDLE
//   i_we       1 = write, 0 = read (latched with go)
//   i_T1       address-setup count  (phase = T1+1 cycles)
//   i_T2       strobe-active count  (phase >= T2+1 cycles)
//   i_Teoc     recovery count       (phase = Teoc+1 cycles)
//   i_IORDYen  enable IORDY stretching of t2 (latched with go)
//   i_IORDY    device ready, already synchronous to i_clk
//   i_d        write data (latched with go)
//   i_dd       ATA data bus input
//   o_dd       registered write data to the bus
//   o_oe       bus output enable
//   o_dior     DIOR strobe (active-high)
//   o_diow     DIOW strobe (active-high)
//   o_busy     cycle in progress
//   o_done     one-cycle pulse in the first recovery cycle
//   o_q        latched read data
// -----------------------------------------------------------------------------
module pio_tctrl #(
  parameter int TWIDTH = 8,
  parameter int DWIDTH = 16
) (
  input  logic              i_clk,
  input  logic              i_nReset,
  input  logic              i_go,
  input  logic              i_we,
  input  logic [TWIDTH-1:0] i_T1,
  input  logic [TWIDTH-1:0] i_T2,
  input  logic [TWIDTH-1:0] i_Teoc,
  input  logic              i_IORDYen,
  input  logic              i_IORDY,
  input  logic [DWIDTH-1:0] i_d,
  input  logic [DWIDTH-1:0] i_dd,
  output logic [DWIDTH-1:0] o_dd,
  output logic              o_oe,
  output logic              o_dior,
  output logic              o_diow,
  output logic              o_busy,
  output logic              o_done,
  output logic [DWIDTH-1:0] o_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_TEOC = 2'd3
  } state_t;

  localparam logic [TWIDTH-1:0] CNT_ZERO = {TWIDTH{1'b0}};
  localparam logic [TWIDTH-1:0] CNT_ONE  = {{(TWIDTH-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [TWIDTH-1:0]   r_cnt;
  logic                r_we;
  logic                r_iordy_en;
  logic [TWIDTH-1:0]   r_t2;
  logic [TWIDTH-1:0]   r_teoc;
  logic [DWIDTH-1:0]   r_dd_o;
  logic [DWIDTH-1:0]   r_q;
  logic                r_busy;
  logic                r_done;
  logic                r_dior;
  logic                r_diow;
  logic                r_oe;

  state_t              w_state_nxt;
  logic [TWIDTH-1:0]   w_cnt_nxt;
  logic                w_start;
  logic                w_cnt_zero;
  logic                w_t2_exit;
  logic                w_we_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_dior_nxt;
  logic                w_diow_nxt;
  logic                w_oe_nxt;

  assign w_start    = (r_state == S_IDLE) && i_go;
  assign w_cnt_zero = (r_cnt == CNT_ZERO);
  // t2 ends only once the count has run out and the device is ready (if asked)
  assign w_t2_exit  = (r_state == S_T2) && w_cnt_zero && (!r_iordy_en || i_IORDY);

  // State register, phase counter, cycle parameters and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_nReset) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_ZERO;
      r_we       <= 1'b0;
      r_iordy_en <= 1'b0;
      r_t2       <= CNT_ZERO;
      r_teoc     <= CNT_ZERO;
      r_dd_o     <= {DWIDTH{1'b0}};
      r_q        <= {DWIDTH{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dior     <= 1'b0;
      r_diow     <= 1'b0;
      r_oe       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_start) begin
        r_we       <= i_we;
        r_iordy_en <= i_IORDYen;
        r_t2       <= i_T2;
        r_teoc     <= i_Teoc;
        r_dd_o     <= i_d;
      end
      // read data is captured on the edge that closes t2
      if (w_t2_exit && !r_we) begin
        r_q <= i_dd;
      end
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_dior <= w_dior_nxt;
      r_diow <= w_diow_nxt;
      r_oe   <= w_oe_nxt;
    end
  end

  // Next-state and phase-counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_T1;
          w_cnt_nxt   = i_T1;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = r_cnt;
        end
      end
      S_T1: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_T2;
          w_cnt_nxt   = r_t2;
        end else begin
          w_state_nxt = S_T1;
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      S_T2: begin
        if (w_t2_exit) begin
          w_state_nxt = S_TEOC;
          w_cnt_nxt   = r_teoc;
        end else if (!w_cnt_zero) begin
          w_state_nxt = S_T2;
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end else begin
          // count exhausted, waiting on IORDY: hold at zero
          w_state_nxt = S_T2;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      S_TEOC: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = S_TEOC;
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state so that the outputs are registered
  always_comb begin
    // direction must reflect the value being latched on the go edge
    w_we_nxt   = w_start ? i_we : r_we;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_oe_nxt   = (w_state_nxt != S_IDLE) && w_we_nxt;
    w_dior_nxt = (w_state_nxt == S_T2) && !w_we_nxt;
    w_diow_nxt = (w_state_nxt == S_T2) && w_we_nxt;
    w_done_nxt = w_t2_exit;
  end

  assign o_dd   = r_dd_o;
  assign o_oe   = r_oe;
  assign o_dior = r_dior;
  assign o_diow = r_diow;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_q    = r_q;

endmodule
